// File: rtl/medidor_de_semiperiodo.sv
// medidor_de_semiperiodo
// Measures the half-period of a slow, asynchronous divided clock (clk_lento)
// in units of the system clock, flags whether it is within tolerance of the
// expected value, and declares the input lost when it stops toggling.
//
// Ports
//   clk          in   system clock, all logic on its rising edge
//   rst_n        in   asynchronous active-low reset
//   clk_lento    in   divided clock under measurement (asynchronous to clk)
//   tick_sub     out  one-cycle pulse per detected rising edge of clk_lento
//   tick_baj     out  one-cycle pulse per detected falling edge of clk_lento
//   semiperiodo  out  clk cycles between the last two detected edges
//   valido       out  semiperiodo holds a measurement since last loss/reset
//   en_rango     out  valido and |semiperiodo - ESPERADO| <= TOL
//   perdido      out  no edge detected for TIMEOUT cycles
`timescale 1ns/1ps

module medidor_de_semiperiodo #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 200,
  parameter int ESPERADO    = 26,
  parameter int TOL         = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_lento,
  output logic             tick_sub,
  output logic             tick_baj,
  output logic [CNT_W-1:0] semiperiodo,
  output logic             valido,
  output logic             en_rango,
  output logic             perdido
);

  // Warm-up counter width: must be able to hold SYNC_STAGES+1.
  localparam int                      WARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0]       WARM_DONE = WARM_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]        CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]        TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic signed [CNT_W:0]   ESP_C     = (CNT_W + 1)'(ESPERADO);
  localparam logic signed [CNT_W:0]   TOL_C     = (CNT_W + 1)'(TOL);

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    MIDIENDO = 2'd1,
    VALIDO   = 2'd2,
    PERDIDO  = 2'd3
  } estado_t;

  // Tolerance test done one bit wider and signed so that a small count
  // minus ESPERADO goes negative instead of wrapping to a huge value.
  function automatic logic dentro_de_tol(input logic [CNT_W-1:0] v);
    logic signed [CNT_W:0] dif;
    logic signed [CNT_W:0] mag;
    dif = $signed({1'b0, v}) - ESP_C;
    mag = dif[CNT_W] ? -dif : dif;
    return (mag <= TOL_C);
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [WARM_W-1:0]      warm_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  estado_t                state_q, state_d;
  logic                   tick_sub_q, tick_sub_d;
  logic                   tick_baj_q, tick_baj_d;
  logic [CNT_W-1:0]       semi_q, semi_d;
  logic                   valido_q, valido_d;
  logic                   en_rango_q, en_rango_d;
  logic                   perdido_q, perdido_d;

  logic sync_last_s;
  logic armed_s;
  logic edge_s;

  assign sync_last_s = sync_q[SYNC_STAGES-1];
  // The reset value of the chain may differ from the real input level; the
  // resulting mismatch is visible only during the warm-up window, so edges
  // are ignored until the chain and history have settled.
  assign armed_s     = (warm_q == WARM_DONE);
  assign edge_s      = armed_s && (sync_last_s != hist_q);

  // Synchronizer chain, history flop and post-reset warm-up counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      hist_q <= 1'b0;
      warm_q <= {WARM_W{1'b0}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_lento};
      hist_q <= sync_last_s;
      if (warm_q != WARM_DONE) begin
        warm_q <= warm_q + WARM_W'(1);
      end else begin
        warm_q <= warm_q;
      end
    end
  end

  // Interval counter: restarts at 1 on an edge so the value seen on the
  // next edge equals the distance between the two detections.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_s) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ESPERA;
      cnt_q      <= {CNT_W{1'b0}};
      tick_sub_q <= 1'b0;
      tick_baj_q <= 1'b0;
      semi_q     <= {CNT_W{1'b0}};
      valido_q   <= 1'b0;
      en_rango_q <= 1'b0;
      perdido_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tick_sub_q <= tick_sub_d;
      tick_baj_q <= tick_baj_d;
      semi_q     <= semi_d;
      valido_q   <= valido_d;
      en_rango_q <= en_rango_d;
      perdido_q  <= perdido_d;
    end
  end

  // Next-state logic; an edge takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ESPERA: begin
        if (edge_s) begin
          state_d = MIDIENDO;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d = PERDIDO;
        end else begin
          state_d = ESPERA;
        end
      end
      MIDIENDO, VALIDO: begin
        if (edge_s) begin
          state_d = VALIDO;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d = PERDIDO;
        end else begin
          state_d = state_q;
        end
      end
      PERDIDO: begin
        if (edge_s) begin
          state_d = MIDIENDO;
        end else begin
          state_d = PERDIDO;
        end
      end
      default: state_d = ESPERA;
    endcase
  end

  // Output logic, computed from the next state so the registered flags
  // track the state register exactly.
  always_comb begin
    tick_sub_d = edge_s && sync_last_s;
    tick_baj_d = edge_s && !sync_last_s;
    valido_d   = (state_d == VALIDO);
    perdido_d  = (state_d == PERDIDO);
    semi_d     = semi_q;
    en_rango_d = 1'b0;
    if (state_d == VALIDO) begin
      // Entering or staying in VALIDO on an edge means a fresh measurement.
      if (edge_s) begin
        semi_d     = cnt_q;
        en_rango_d = dentro_de_tol(cnt_q);
      end else begin
        semi_d     = semi_q;
        en_rango_d = en_rango_q;
      end
    end else begin
      // Outside VALIDO the last measurement is kept but not qualified.
      semi_d     = semi_q;
      en_rango_d = 1'b0;
    end
  end

  assign tick_sub    = tick_sub_q;
  assign tick_baj    = tick_baj_q;
  assign semiperiodo = semi_q;
  assign valido      = valido_q;
  assign en_rango    = en_rango_q;
  assign perdido     = perdido_q;

endmodule

// File: tb/tb_medidor_de_semiperiodo.sv
// Directed testbench for medidor_de_semiperiodo (default parameters).
// clk_lento is toggled a fixed number of clk cycles after its previous
// toggle; with that timing the measured half-period equals the interval.
`timescale 1ns/1ps

module tb_medidor_de_semiperiodo;

  logic       clk;
  logic       rst_n;
  logic       clk_lento;
  logic       tick_sub;
  logic       tick_baj;
  logic [7:0] semiperiodo;
  logic       valido;
  logic       en_rango;
  logic       perdido;

  int checks = 0;
  int errors = 0;
  int since  = 0;

  // Event monitor state (written only by the monitor processes).
  int cyc      = 0;
  int n_sub    = 0;
  int n_baj    = 0;
  int n_perd   = 0;
  int last_sub = 0;
  int last_baj = 0;

  int snap_a;
  int snap_b;

  medidor_de_semiperiodo dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_lento   (clk_lento),
    .tick_sub    (tick_sub),
    .tick_baj    (tick_baj),
    .semiperiodo (semiperiodo),
    .valido      (valido),
    .en_rango    (en_rango),
    .perdido     (perdido)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Tick and loss monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (tick_sub) begin
      n_sub    <= n_sub + 1;
      last_sub <= cyc;
    end
    if (tick_baj) begin
      n_baj    <= n_baj + 1;
      last_baj <= cyc;
    end
    if (perdido) n_perd <= n_perd + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      since++;
    end
  endtask

  // Toggle clk_lento h clk cycles after its previous toggle.
  task automatic toggle_at(input int h);
    step(h - since);
    #1 clk_lento = ~clk_lento;
    since = 0;
  endtask

  // Wait for the edge to propagate (sync + register) and sample at negedge.
  task automatic settle();
    step(4);
    @(negedge clk);
  endtask

  task automatic check_meas(input string tag, input int sp, input int v, input int r);
    check_val({tag, "_semi"}, 32'(semiperiodo), 32'(sp));
    check_val({tag, "_valido"}, 32'(valido), 32'(v));
    check_val({tag, "_en_rango"}, 32'(en_rango), 32'(r));
  endtask

  initial begin
    rst_n     = 1'b0;
    clk_lento = 1'b0;
    step(3);
    @(negedge clk);
    check_val("rst_tick_sub", 32'(tick_sub), 32'd0);
    check_val("rst_tick_baj", 32'(tick_baj), 32'd0);
    check_val("rst_semi", 32'(semiperiodo), 32'd0);
    check_val("rst_valido", 32'(valido), 32'd0);
    check_val("rst_en_rango", 32'(en_rango), 32'd0);
    check_val("rst_perdido", 32'(perdido), 32'd0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    since = 0;

    // Nominal half-period 26.
    toggle_at(26);
    settle();
    check_val("a1_n_sub", 32'(n_sub), 32'd1);
    check_val("a1_n_baj", 32'(n_baj), 32'd0);
    check_val("a1_valido", 32'(valido), 32'd0);
    toggle_at(26);
    settle();
    check_meas("a2", 26, 1, 1);
    toggle_at(26);
    toggle_at(26);
    settle();
    check_meas("a4", 26, 1, 1);
    check_val("a4_n_sub", 32'(n_sub), 32'd2);
    check_val("a4_n_baj", 32'(n_baj), 32'd2);
    check_val("a4_spacing", 32'(last_baj - last_sub), 32'd26);

    // Tolerance boundaries around ESPERADO=26, TOL=1.
    toggle_at(30);
    settle();
    check_meas("b30", 30, 1, 0);
    toggle_at(25);
    settle();
    check_meas("b25", 25, 1, 1);
    toggle_at(27);
    settle();
    check_meas("b27", 27, 1, 1);
    toggle_at(28);
    settle();
    check_meas("b28", 28, 1, 0);
    toggle_at(24);
    settle();
    check_meas("b24", 24, 1, 0);

    // Loss: perdido exactly 200 cycles after the last tick.
    step(202 - since);
    @(negedge clk);
    check_val("c_perdido_early", 32'(perdido), 32'd0);
    step(1);
    @(negedge clk);
    check_val("c_perdido", 32'(perdido), 32'd1);
    check_meas("c_lost", 24, 0, 0);
    toggle_at(250);
    settle();
    check_val("c_rec1_perdido", 32'(perdido), 32'd0);
    check_meas("c_rec1", 24, 0, 0);
    toggle_at(26);
    settle();
    check_meas("c_rec2", 26, 1, 1);

    // Edge in the same cycle the counter reaches TIMEOUT: edge wins.
    snap_a = n_perd;
    toggle_at(200);
    settle();
    check_val("d_no_perdido", 32'(n_perd - snap_a), 32'd0);
    check_meas("d", 200, 1, 0);

    // Short asynchronous reset pulse between edges.
    step(10);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #0.5;
    check_val("e_rst_semi", 32'(semiperiodo), 32'd0);
    check_val("e_rst_valido", 32'(valido), 32'd0);
    check_val("e_rst_en_rango", 32'(en_rango), 32'd0);
    check_val("e_rst_perdido", 32'(perdido), 32'd0);
    #0.5 rst_n = 1'b1;
    toggle_at(50);
    settle();
    check_meas("e1", 0, 0, 0);
    toggle_at(26);
    settle();
    check_meas("e2", 26, 1, 1);

    // clk_lento high through reset and held: no tick, loss after 200.
    rst_n     = 1'b0;
    clk_lento = 1'b1;
    step(3);
    snap_b = n_sub + n_baj;
    @(posedge clk);
    #1 rst_n = 1'b1;
    since = 0;
    step(200);
    @(negedge clk);
    check_val("f_perdido_early", 32'(perdido), 32'd0);
    step(1);
    @(negedge clk);
    check_val("f_perdido", 32'(perdido), 32'd1);
    check_val("f_valido", 32'(valido), 32'd0);
    step(20);
    @(negedge clk);
    check_val("f_no_tick", 32'(n_sub + n_baj - snap_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/medidor_de_semiperiodo.md
MEDIDOR_DE_SEMIPERIODO -- requirements
Module: medidor_de_semiperiodo

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on clk_lento (minimum 2).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the interval counter and of semiperiodo.
REQ-003 The block SHALL have parameter TIMEOUT, default 200, meaning the clk cycles without a detected edge before the input is declared lost (1 < TIMEOUT < 2^CNT_W).
REQ-004 The block SHALL have parameter ESPERADO, default 26, meaning the expected half-period in clk cycles.
REQ-005 The block SHALL have parameter TOL, default 1, meaning the allowed absolute deviation from ESPERADO.
REQ-006 clk  input  1  system clock; all logic is on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 clk_lento  input  1  divided clock under measurement, asynchronous to clk.
REQ-009 tick_sub  output  1  one-cycle pulse per detected rising edge of clk_lento.
REQ-010 tick_baj  output  1  one-cycle pulse per detected falling edge of clk_lento.
REQ-011 semiperiodo  output  CNT_W  clk cycles between the last two consecutive detected edges, of either polarity.
REQ-012 valido  output  1  semiperiodo holds a measurement taken since the last loss or reset.
REQ-013 en_rango  output  1  valido and |semiperiodo - ESPERADO| <= TOL.
REQ-014 perdido  output  1  no edge detected for TIMEOUT cycles.

Function
REQ-015 clk_lento SHALL pass through SYNC_STAGES flops, then one history flop; an edge SHALL be detected when the last sync flop differs from the history flop.
REQ-016 tick_sub/tick_baj SHALL be registered and assert SYNC_STAGES+1 clk edges after the first clk edge that samples the new clk_lento level.
REQ-017 Edges SHALL be suppressed for the first SYNC_STAGES+1 cycles after rst_n deasserts, so a static level at reset yields no tick.
REQ-018 Counter cnt SHALL load 1 on a detected-edge cycle, otherwise increment, saturating at 2^CNT_W-1.
REQ-019 The FSM SHALL have states ESPERA, MIDIENDO, VALIDO and PERDIDO.
REQ-020 ESPERA: edge -> MIDIENDO; cnt == TIMEOUT -> PERDIDO.
REQ-021 MIDIENDO: edge -> VALIDO, with semiperiodo <= cnt; cnt == TIMEOUT -> PERDIDO.
REQ-022 VALIDO: edge -> VALIDO, with semiperiodo <= cnt; cnt == TIMEOUT -> PERDIDO.
REQ-023 PERDIDO: edge -> MIDIENDO, with no semiperiodo update.
REQ-024 An edge and cnt == TIMEOUT in the same cycle SHALL be treated as an edge; the edge wins.
REQ-025 valido SHALL be 1 exactly while in state VALIDO; perdido SHALL be 1 exactly while in state PERDIDO; both SHALL be registered.
REQ-026 On entry to PERDIDO, semiperiodo SHALL hold its last value while valido and en_rango go to 0.
REQ-027 en_rango SHALL be registered and update in the same cycle as semiperiodo and valido; the comparison SHALL use CNT_W+1-bit signed arithmetic with no wrap.
REQ-028 The measured value SHALL equal t2 - t1, where t1 and t2 are the cycles of consecutive edge detections.

Reset
REQ-029 While rst_n = 0, all flops SHALL clear immediately: sync chain, history and ticks to 0, semiperiodo and cnt to 0, valido, en_rango and perdido to 0, state ESPERA.
REQ-030 Reset asserted mid-measurement SHALL discard the measurement; after release, behaviour SHALL be as from power-up, including REQ-017.

Verification
REQ-031 clk_lento toggling every 26 clk cycles -> after the second edge valido=1; each later edge gives semiperiodo=26, en_rango=1, and tick_sub/tick_baj alternating 26 cycles apart.
REQ-032 Half-period 30, with defaults -> semiperiodo=30, valido=1, en_rango=0; half-period 25 or 27 -> en_rango=1.
REQ-033 clk_lento held static after lock -> perdido=1 exactly 200 cycles after the last edge, valido=0, semiperiodo retained; the next edge -> MIDIENDO, and the edge after that -> valido=1.
REQ-034 clk_lento=1 during reset, then held high -> no tick ever, perdido=1 after 200 cycles.
REQ-035 Edge arriving in the same cycle cnt reaches TIMEOUT -> no perdido pulse; semiperiodo=TIMEOUT, valido=1.
REQ-036 rst_n pulsed low for 1 ns between edges -> all outputs 0 asynchronously; after release, the first edge gives no measurement and the second gives a correct semiperiodo.
